// File: rtl/missile_hit_unit.sv
// missile_hit_unit
// Owns the player missile: launches it from the ship on the fire key, moves it
// up once per frame tick, and latches which of the 12 aliens it has struck.
//
// Ports
//   Clk, Reset          system clock, asynchronous active-low reset
//   frame_clk           vsync-rate strobe (synchronous to Clk), rising edge = tick
//   keycode             current USB keycode
//   ShipX/ShipY/ShipS   ship top-left position and size
//   AlienX/AlienY       packed 12 x 10-bit alien positions, alien1 in [9:0]
//   AlienS              common alien size
//   wave_reset          single-cycle pulse clearing all hit flags
//   MissileX/MissileY   missile top-left position
//   MissileS            missile width (constant)
//   missile_sight       missile is visible and live
//   AlienHit            sticky per-alien hit flags
//   hit_count           number of aliens hit
//   wave_clear          all 12 aliens hit
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no missile; launch on tick with fire key, armed, ship high enough
// ST_FLYING   | missile live; per tick: hit check, top exit, or move up
// ST_COOLDOWN | missile gone; count COOLDOWN_FRAMES ticks before next launch

module missile_hit_unit #(
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter int         MISSILE_SIZE    = 4,
    parameter int         MISSILE_STEP    = 6,
    parameter int         COOLDOWN_FRAMES = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_clk,
    input  logic [7:0]   keycode,
    input  logic [9:0]   ShipX,
    input  logic [9:0]   ShipY,
    input  logic [9:0]   ShipS,
    input  logic [119:0] AlienX,
    input  logic [119:0] AlienY,
    input  logic [9:0]   AlienS,
    input  logic         wave_reset,
    output logic [9:0]   MissileX,
    output logic [9:0]   MissileY,
    output logic [9:0]   MissileS,
    output logic         missile_sight,
    output logic [11:0]  AlienHit,
    output logic [3:0]   hit_count,
    output logic         wave_clear
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLYING,
        ST_COOLDOWN
    } state_t;

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [9:0]  SIZE_W   = 10'(MISSILE_SIZE);
    localparam logic [9:0]  HEIGHT_W = 10'(2 * MISSILE_SIZE);
    localparam logic [9:0]  STEP_W   = 10'(MISSILE_STEP);
    localparam logic [10:0] SIZE_X   = 11'(MISSILE_SIZE);
    localparam logic [10:0] HEIGHT_X = 11'(2 * MISSILE_SIZE);

    state_t            state_q, state_d;
    logic [9:0]        missile_x_q, missile_x_d;
    logic [9:0]        missile_y_q, missile_y_d;
    logic              sight_q, sight_d;
    logic [11:0]       alien_hit_q, alien_hit_d;
    logic [3:0]        hit_count_q, hit_count_d;
    logic              wave_clear_q, wave_clear_d;
    logic              armed_q, armed_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              frame_q;

    logic              tick;
    logic [11:0]       overlap;
    logic [11:0]       hit_onehot;

    assign tick = frame_clk & ~frame_q;

    // Rectangle overlap per live alien; 11-bit sums cannot wrap.
    always_comb begin
        overlap = '0;
        for (int i = 0; i < 12; i++) begin
            overlap[i] = ~alien_hit_q[i]
                && ({1'b0, missile_x_q} < {1'b0, AlienX[10*i +: 10]} + {1'b0, AlienS})
                && ({1'b0, AlienX[10*i +: 10]} < {1'b0, missile_x_q} + SIZE_X)
                && ({1'b0, missile_y_q} < {1'b0, AlienY[10*i +: 10]} + {1'b0, AlienS})
                && ({1'b0, AlienY[10*i +: 10]} < {1'b0, missile_y_q} + HEIGHT_X);
        end
    end

    // Isolate the lowest-index overlapping alien.
    assign hit_onehot = overlap & (~overlap + 12'd1);

    always_comb begin
        state_d      = state_q;
        missile_x_d  = missile_x_q;
        missile_y_d  = missile_y_q;
        sight_d      = sight_q;
        alien_hit_d  = alien_hit_q;
        hit_count_d  = hit_count_q;
        armed_d      = armed_q;
        cd_d         = cd_q;

        if (tick && keycode != FIRE_KEY) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && keycode == FIRE_KEY && armed_q && ShipY >= HEIGHT_W) begin
                    missile_x_d = ShipX + ((ShipS - SIZE_W) >> 1);
                    missile_y_d = ShipY - HEIGHT_W;
                    sight_d     = 1'b1;
                    armed_d     = 1'b0;
                    state_d     = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (tick) begin
                    if (|overlap) begin
                        alien_hit_d = alien_hit_q | hit_onehot;
                        hit_count_d = hit_count_q + 4'd1;
                        sight_d     = 1'b0;
                        cd_d        = CD_LOAD;
                        state_d     = ST_COOLDOWN;
                    end else if (missile_y_q < STEP_W) begin
                        sight_d     = 1'b0;
                        cd_d        = CD_LOAD;
                        state_d     = ST_COOLDOWN;
                    end else begin
                        missile_y_d = missile_y_q - STEP_W;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    cd_d = cd_q - CD_ONE;
                    if (cd_q == CD_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A coincident hit is dropped; the missile itself still ends normally.
        if (wave_reset) begin
            alien_hit_d = '0;
            hit_count_d = '0;
        end

        wave_clear_d = &alien_hit_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            missile_x_q  <= '0;
            missile_y_q  <= '0;
            sight_q      <= 1'b0;
            alien_hit_q  <= '0;
            hit_count_q  <= '0;
            wave_clear_q <= 1'b0;
            armed_q      <= 1'b1;
            cd_q         <= '0;
            frame_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            missile_x_q  <= missile_x_d;
            missile_y_q  <= missile_y_d;
            sight_q      <= sight_d;
            alien_hit_q  <= alien_hit_d;
            hit_count_q  <= hit_count_d;
            wave_clear_q <= wave_clear_d;
            armed_q      <= armed_d;
            cd_q         <= cd_d;
            frame_q      <= frame_clk;
        end
    end

    assign MissileX      = missile_x_q;
    assign MissileY      = missile_y_q;
    assign MissileS      = SIZE_W;
    assign missile_sight = sight_q;
    assign AlienHit      = alien_hit_q;
    assign hit_count     = hit_count_q;
    assign wave_clear    = wave_clear_q;

endmodule

// File: tb/tb_missile_hit_unit.sv
module tb_missile_hit_unit;

    localparam logic [7:0] FIRE = 8'h2C;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         frame_clk = 1'b0;
    logic [7:0]   keycode = 8'h00;
    logic [9:0]   ShipX, ShipY, ShipS;
    logic [119:0] AlienX, AlienY;
    logic [9:0]   AlienS;
    logic         wave_reset = 1'b0;
    logic [9:0]   MissileX, MissileY, MissileS;
    logic         missile_sight;
    logic [11:0]  AlienHit;
    logic [3:0]   hit_count;
    logic         wave_clear;

    int ship_x = 300, ship_y = 420, ship_s = 40;
    int alien_x [12];
    int alien_y [12];
    int alien_s = 25;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign ShipX  = 10'(ship_x);
    assign ShipY  = 10'(ship_y);
    assign ShipS  = 10'(ship_s);
    assign AlienS = 10'(alien_s);

    always_comb begin
        AlienX = '0;
        AlienY = '0;
        for (int i = 0; i < 12; i++) begin
            AlienX[10*i +: 10] = 10'(alien_x[i]);
            AlienY[10*i +: 10] = 10'(alien_y[i]);
        end
    end

    missile_hit_unit dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .ShipX(ShipX), .ShipY(ShipY), .ShipS(ShipS),
        .AlienX(AlienX), .AlienY(AlienY), .AlienS(AlienS),
        .wave_reset(wave_reset),
        .MissileX(MissileX), .MissileY(MissileY), .MissileS(MissileS),
        .missile_sight(missile_sight), .AlienHit(AlienHit),
        .hit_count(hit_count), .wave_clear(wave_clear)
    );

    // Behavioural model: mode 0 = no missile, 1 = in flight, 2 = waiting to re-arm.
    int        m_mode, m_mx, m_my, m_cd;
    bit        m_sight, m_armed;
    bit [11:0] m_hits;

    typedef struct {
        int        mx;
        int        my;
        bit        sight;
        bit [11:0] hits;
        int        cnt;
        bit        wc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void model_reset();
        m_mode = 0; m_mx = 0; m_my = 0; m_cd = 0;
        m_sight = 0; m_armed = 1; m_hits = '0;
    endfunction

    function automatic int find_hit();
        for (int i = 0; i < 12; i++) begin
            if (!m_hits[i] && m_mx < alien_x[i] + alien_s && alien_x[i] < m_mx + 4 &&
                m_my < alien_y[i] + alien_s && alien_y[i] < m_my + 8)
                return i;
        end
        return -1;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.mx = m_mx; e.my = m_my; e.sight = m_sight; e.hits = m_hits;
        e.cnt = $countones(m_hits); e.wc = (m_hits == 12'hFFF);
        exp_q.push_back(e);
    endfunction

    function automatic void model_tick(bit wr);
        int h;
        case (m_mode)
            0: if (keycode == FIRE && m_armed && ship_y >= 8) begin
                   m_mx = (ship_x + (((ship_s - 4) & 1023) >> 1)) & 1023;
                   m_my = ship_y - 8;
                   m_sight = 1; m_armed = 0; m_mode = 1;
               end
            1: begin
                   h = find_hit();
                   if (h >= 0) begin
                       m_hits[h] = 1'b1;
                       m_sight = 0; m_mode = 2; m_cd = 8;
                   end else if (m_my < 6) begin
                       m_sight = 0; m_mode = 2; m_cd = 8;
                   end else begin
                       m_my = m_my - 6;
                   end
               end
            default: begin
                   m_cd = m_cd - 1;
                   if (m_cd == 0) m_mode = 0;
               end
        endcase
        if (keycode != FIRE) m_armed = 1;
        if (wr) m_hits = '0;
    endfunction

    task automatic tick(input bit wr);
        @(negedge Clk);
        frame_clk  = 1'b1;
        wave_reset = wr;
        model_tick(wr);
        push_exp();
        @(negedge Clk);
        frame_clk  = 1'b0;
        wave_reset = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge Clk);
    endtask

    task automatic pulse_wave_reset();
        @(negedge Clk);
        wave_reset = 1'b1;
        m_hits = '0;
        push_exp();
        @(negedge Clk);
        wave_reset = 1'b0;
    endtask

    task automatic run_to_idle();
        for (int k = 0; k < 200 && m_mode != 0; k++) tick(1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (missile_sight !== 1'b0 || AlienHit !== 12'h000 || MissileX !== 10'd0 ||
            MissileY !== 10'd0 || hit_count !== 4'd0 || wave_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got sight=%0b hits=%03h mx=%0d my=%0d cnt=%0d wc=%0b, expected all zero",
                     missile_sight, AlienHit, MissileX, MissileY, hit_count, wave_clear);
        end
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic aliens_far();
        for (int i = 0; i < 12; i++) begin
            alien_x[i] = 600 + 20 * i;
            alien_y[i] = 50;
        end
        alien_s = 25;
    endtask

    // Monitor: every tick or wave_reset pulse produces one registered response.
    initial begin
        bit   fprev;
        bit   ev;
        exp_t e;
        fprev = 1'b0;
        forever begin
            @(posedge Clk);
            ev = (frame_clk && !fprev) || wave_reset;
            fprev = frame_clk;
            if (ev && Reset) begin
                @(negedge Clk);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_event: DUT response with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (MissileX !== 10'(e.mx) || MissileY !== 10'(e.my) ||
                        missile_sight !== e.sight || AlienHit !== e.hits ||
                        hit_count !== 4'(e.cnt) || wave_clear !== e.wc || MissileS !== 10'd4) begin
                        errors++;
                        $display("FAIL out_event: got mx=%0d my=%0d sight=%0b hits=%03h cnt=%0d wc=%0b s=%0d expected mx=%0d my=%0d sight=%0b hits=%03h cnt=%0d wc=%0b s=4",
                                 MissileX, MissileY, missile_sight, AlienHit, hit_count, wave_clear, MissileS,
                                 e.mx, e.my, e.sight, e.hits, e.cnt, e.wc);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int rises;
        bit prev_sight;
        int h;

        aliens_far();
        do_reset();

        // Reset then idle
        keycode = 8'h00;
        repeat (5) tick(1'b0);

        // Launch and travel to top exit
        keycode = FIRE;
        tick(1'b0);
        checks++;
        if (MissileX !== 10'd318 || MissileY !== 10'd412 || missile_sight !== 1'b1) begin
            errors++;
            $display("FAIL launch_pos: got mx=%0d my=%0d sight=%0b, expected mx=318 my=412 sight=1",
                     MissileX, MissileY, missile_sight);
        end
        keycode = 8'h00;
        tick(1'b0);
        checks++;
        if (MissileY !== 10'd406) begin
            errors++;
            $display("FAIL first_step: got my=%0d, expected 406", MissileY);
        end
        run_to_idle();

        // Hit alien1 on the 49th tick after launch
        alien_x[0] = 310; alien_y[0] = 100;
        keycode = FIRE;
        tick(1'b0);
        keycode = 8'h00;
        repeat (48) tick(1'b0);
        checks++;
        if (MissileY !== 10'd124 || missile_sight !== 1'b1 || AlienHit !== 12'h000) begin
            errors++;
            $display("FAIL pre_hit: got my=%0d sight=%0b hits=%03h, expected my=124 sight=1 hits=000",
                     MissileY, missile_sight, AlienHit);
        end
        tick(1'b0);
        checks++;
        if (AlienHit !== 12'h001 || hit_count !== 4'd1 || missile_sight !== 1'b0) begin
            errors++;
            $display("FAIL hit_alien1: got hits=%03h cnt=%0d sight=%0b, expected hits=001 cnt=1 sight=0",
                     AlienHit, hit_count, missile_sight);
        end
        run_to_idle();

        // Priority with a dead alien1: alien2 and alien3 overlap too
        alien_x[1] = 310; alien_y[1] = 100;
        alien_x[2] = 312; alien_y[2] = 95;
        keycode = FIRE;
        tick(1'b0);
        keycode = 8'h00;
        run_to_idle();
        checks++;
        if (AlienHit !== 12'h003) begin
            errors++;
            $display("FAIL priority: got hits=%03h, expected 003", AlienHit);
        end

        // Hold fire key through 30 ticks: exactly one launch
        aliens_far();
        keycode = FIRE;
        rises = 0;
        prev_sight = missile_sight;
        repeat (30) begin
            tick(1'b0);
            if (missile_sight && !prev_sight) rises++;
            prev_sight = missile_sight;
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL hold_key: got %0d launches, expected 1", rises);
        end

        // Reset while flying
        do_reset();
        keycode = 8'h00;
        tick(1'b0);

        // Hit all twelve
        for (int i = 0; i < 12; i++) begin
            alien_x[i] = 310; alien_y[i] = 100;
        end
        for (int s = 0; s < 12; s++) begin
            keycode = FIRE;
            tick(1'b0);
            keycode = 8'h00;
            run_to_idle();
        end
        checks++;
        if (wave_clear !== 1'b1 || hit_count !== 4'd12 || AlienHit !== 12'hFFF) begin
            errors++;
            $display("FAIL wave_clear: got wc=%0b cnt=%0d hits=%03h, expected wc=1 cnt=12 hits=FFF",
                     wave_clear, hit_count, AlienHit);
        end

        // Stand-alone wave_reset, then wave_reset coincident with a hit
        pulse_wave_reset();
        keycode = FIRE;
        tick(1'b0);
        keycode = 8'h00;
        for (int k = 0; k < 200 && m_mode == 1 && find_hit() < 0; k++) tick(1'b0);
        tick(1'b1);
        checks++;
        if (AlienHit !== 12'h000 || hit_count !== 4'd0 || wave_clear !== 1'b0) begin
            errors++;
            $display("FAIL wr_vs_hit: got hits=%03h cnt=%0d wc=%0b, expected all zero",
                     AlienHit, hit_count, wave_clear);
        end
        run_to_idle();

        // Randomised play
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) begin
                ship_x = $urandom_range(200, 420);
                ship_y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(8, 479);
                ship_s = $urandom_range(0, 63);
                alien_s = $urandom_range(5, 40);
                for (int i = 0; i < 12; i++) begin
                    alien_x[i] = $urandom_range(250, 450);
                    alien_y[i] = $urandom_range(0, 479);
                end
            end
            keycode = ($urandom_range(0, 1) == 1) ? FIRE : 8'($urandom_range(0, 255));
            h = $urandom_range(0, 15);
            if (h == 0) pulse_wave_reset();
            tick(h == 1);
        end

        repeat (5) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unconsumed expectations, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
